gc_gate_scheduler: RTL

//  Sequencer for the single-gate garbling engine (combinational, one AND-type gate per evaluation).

---
 rtl/gc_gate_scheduler_if.sv | 13 +
 rtl/gc_gate_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gc_gate_scheduler_if.sv
// Garbled-table output stream between the gate scheduler and the table FIFO.
interface gc_gate_scheduler_if #(
  parameter int unsigned S = 20,
  parameter int unsigned K = 128
) ();
  logic           tbl_valid;
  logic           tbl_ready;
  logic [2*K-1:0] tbl_data;
  logic [S-1:0]   tbl_gid;

  modport master (output tbl_valid, output tbl_data, output tbl_gid, input tbl_ready);
  modport slave  (input tbl_valid, input tbl_data, input tbl_gid, output tbl_ready);
endinterface

// File: rtl/gc_gate_scheduler.sv
// Walks gate descriptors in gid order, runs non-free gates through the garbling engine and
// free-XOR gates locally. Define GC_ENG_PIPE_EN when the engine has one output register stage.
module gc_gate_scheduler #(
  parameter int unsigned S  = 20,
  parameter int unsigned K  = 128,
  parameter int unsigned AW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [S-1:0]        num_gates,
  input  logic [K-1:0]        R,
  output logic                busy,
  output logic                done,
  output logic [S-1:0]        gd_addr,
  input  logic [4+3*AW-1:0]   gd_rdata,
  output logic [AW-1:0]       lb_raddr0,
  output logic [AW-1:0]       lb_raddr1,
  input  logic [K-1:0]        lb_rdata0,
  input  logic [K-1:0]        lb_rdata1,
  output logic                lb_we,
  output logic [AW-1:0]       lb_waddr,
  output logic [K-1:0]        lb_wdata,
  output logic [S-1:0]        eng_gid,
  output logic [3:0]          eng_g_logic,
  output logic [K-1:0]        eng_in0,
  output logic [K-1:0]        eng_in1,
  input  logic [K-1:0]        eng_t0,
  input  logic [K-1:0]        eng_t1,
  input  logic [K-1:0]        eng_out,
  gc_gate_scheduler_if.master tbl
);
  localparam logic [3:0] G_XOR  = 4'b0110;
  localparam logic [3:0] G_XNOR = 4'b1001;

  typedef struct packed {
    logic [3:0]    g_logic;
    logic [AW-1:0] in0_addr;
    logic [AW-1:0] in1_addr;
    logic [AW-1:0] out_addr;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_EWAIT, ST_EMIT, ST_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [S-1:0]   gid_q, gid_d;
  logic [S-1:0]   num_q, num_d;
  desc_t          desc_q, desc_d;
  logic [S-1:0]   eng_gid_q, eng_gid_d;
  logic [3:0]     eng_g_q, eng_g_d;
  logic [K-1:0]   eng_in0_q, eng_in0_d, eng_in1_q, eng_in1_d;
  logic           tbl_valid_q, tbl_valid_d;
  logic [2*K-1:0] tbl_data_q, tbl_data_d;
  logic [S-1:0]   tbl_gid_q, tbl_gid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  desc_t          gd_desc;
  logic           is_free, gd_free, is_last, capture;
  logic [AW-1:0]  lb_raddr0_c, lb_raddr1_c, lb_waddr_c;
  logic           lb_we_c;
  logic [K-1:0]   lb_wdata_c, eng_in0_c, eng_in1_c;

  assign gd_desc = gd_rdata;
  assign is_free = (desc_q.g_logic == G_XOR) || (desc_q.g_logic == G_XNOR);
  assign gd_free = (gd_desc.g_logic == G_XOR) || (gd_desc.g_logic == G_XNOR);
  assign is_last = (gid_q + S'(1)) == num_q;

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    num_d       = num_q;
    desc_d      = desc_q;
    eng_gid_d   = eng_gid_q;
    eng_g_d     = eng_g_q;
    eng_in0_d   = eng_in0_q;
    eng_in1_d   = eng_in1_q;
    tbl_valid_d = tbl_valid_q;
    tbl_data_d  = tbl_data_q;
    tbl_gid_d   = tbl_gid_q;
    done_d      = (state_q == ST_FIN);
    capture     = 1'b0;
    lb_raddr0_c = desc_q.in0_addr;
    lb_raddr1_c = desc_q.in1_addr;
    lb_we_c     = 1'b0;
    lb_waddr_c  = '0;
    lb_wdata_c  = '0;
    eng_in0_c   = eng_in0_q;
    eng_in1_c   = eng_in1_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d   = num_gates;
          gid_d   = '0;
          state_d = (num_gates == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        desc_d      = gd_desc;
        lb_raddr0_c = gd_desc.in0_addr;
        lb_raddr1_c = gd_desc.in1_addr;
        if (!gd_free) begin
          eng_gid_d = gid_q;
          eng_g_d   = gd_desc.g_logic;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_free) begin
          lb_we_c    = 1'b1;
          lb_waddr_c = desc_q.out_addr;
          lb_wdata_c = lb_rdata0 ^ lb_rdata1 ^ ((desc_q.g_logic == G_XNOR) ? R : '0);
          gid_d      = gid_q + S'(1);
          state_d    = is_last ? ST_FIN : ST_FETCH;
        end else begin
          // Engine sees the freshly read labels; keep a copy so they stay put afterwards
          eng_in0_c = lb_rdata0;
          eng_in1_c = lb_rdata1;
          eng_in0_d = lb_rdata0;
          eng_in1_d = lb_rdata1;
`ifdef GC_ENG_PIPE_EN
          state_d = ST_EWAIT;
`else
          capture = 1'b1;
`endif
        end
      end
      ST_EWAIT: begin
`ifdef GC_ENG_PIPE_EN
        capture = 1'b1;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_EMIT: begin
        if (tbl.tbl_ready) begin
          tbl_valid_d = 1'b0;
          gid_d       = gid_q + S'(1);
          state_d     = is_last ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Engine result: single label write and table capture
    if (capture) begin
      lb_we_c     = 1'b1;
      lb_waddr_c  = desc_q.out_addr;
      lb_wdata_c  = eng_out;
      tbl_data_d  = {eng_t0, eng_t1};
      tbl_gid_d   = gid_q;
      tbl_valid_d = 1'b1;
      state_d     = ST_EMIT;
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gid_q       <= '0;
      num_q       <= '0;
      desc_q      <= '0;
      eng_gid_q   <= '0;
      eng_g_q     <= '0;
      eng_in0_q   <= '0;
      eng_in1_q   <= '0;
      tbl_valid_q <= 1'b0;
      tbl_data_q  <= '0;
      tbl_gid_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      num_q       <= num_d;
      desc_q      <= desc_d;
      eng_gid_q   <= eng_gid_d;
      eng_g_q     <= eng_g_d;
      eng_in0_q   <= eng_in0_d;
      eng_in1_q   <= eng_in1_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_data_q  <= tbl_data_d;
      tbl_gid_q   <= tbl_gid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign gd_addr       = gid_q;
  assign lb_raddr0     = lb_raddr0_c;
  assign lb_raddr1     = lb_raddr1_c;
  assign lb_we         = lb_we_c;
  assign lb_waddr      = lb_waddr_c;
  assign lb_wdata      = lb_wdata_c;
  assign eng_gid       = eng_gid_q;
  assign eng_g_logic   = eng_g_q;
  assign eng_in0       = eng_in0_c;
  assign eng_in1       = eng_in1_c;
  assign tbl.tbl_valid = tbl_valid_q;
  assign tbl.tbl_data  = tbl_data_q;
  assign tbl.tbl_gid   = tbl_gid_q;
endmodule
